// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: start/stop/load run-control for a two-digit BCD stopwatch.
// A prescaler divides CLK down to count ticks; the units/tens digits advance
// in BCD on each tick and stop at a programmable nonzero terminal value.
// Optional lap capture is compiled in when BCD_LAP_EN is defined.
module bcd_timer_ctrl #(
    parameter int PRESCALE = 10
) (
    input  logic       CLK,
    input  logic       Clear,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [7:0] target,
`ifdef BCD_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] unidades,
    output logic [3:0] decenas,
    output logic       running,
    output logic       done,
    output logic [7:0] lap_value
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    // Digits above 9 are not legal BCD; saturate them to 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        if (d > 4'd9) begin
            clamp_digit = 4'd9;
        end else begin
            clamp_digit = d;
        end
    endfunction

    state_t      state_r, state_nxt_s;
    logic [3:0]  units_r, units_nxt_s, units_inc_s;
    logic [3:0]  tens_r, tens_nxt_s, tens_inc_s;
    logic [15:0] presc_r, presc_nxt_s;
    logic [7:0]  target_r;
    logic        running_r, done_r, done_nxt_s;
    logic        tick_s, hit_s;

    // BCD increment of the current count and target-match of the result.
    always_comb begin
        units_inc_s = units_r + 4'd1;
        tens_inc_s  = tens_r;
        if (units_r >= 4'd9) begin
            units_inc_s = 4'd0;
            if (tens_r >= 4'd9) begin
                tens_inc_s = 4'd0;
            end else begin
                tens_inc_s = tens_r + 4'd1;
            end
        end else begin
            tens_inc_s = tens_r;
        end
        tick_s = (presc_r == PRESC_MAX);
        hit_s  = (target_r != 8'h00) && ({tens_inc_s, units_inc_s} == target_r);
    end

    // Next-state, count and prescaler logic; stop outranks start, a target hit outranks stop.
    always_comb begin
        state_nxt_s = state_r;
        units_nxt_s = units_r;
        tens_nxt_s  = tens_r;
        presc_nxt_s = presc_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                units_nxt_s = 4'd0;
                tens_nxt_s  = 4'd0;
                presc_nxt_s = 16'd0;
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (tick_s) begin
                    presc_nxt_s = 16'd0;
                    units_nxt_s = units_inc_s;
                    tens_nxt_s  = tens_inc_s;
                end else begin
                    presc_nxt_s = presc_r + 16'd1;
                end
                if (tick_s && hit_s) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                end else if (stop) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                    units_nxt_s = 4'd0;
                    tens_nxt_s  = 4'd0;
                    presc_nxt_s = 16'd0;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                    units_nxt_s = 4'd0;
                    tens_nxt_s  = 4'd0;
                    presc_nxt_s = 16'd0;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                    units_nxt_s = 4'd0;
                    tens_nxt_s  = 4'd0;
                    presc_nxt_s = 16'd0;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                units_nxt_s = 4'd0;
                tens_nxt_s  = 4'd0;
                presc_nxt_s = 16'd0;
            end
        endcase
    end

    // State, count, prescaler and status flag registers.
    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            state_r   <= ST_IDLE;
            units_r   <= 4'd0;
            tens_r    <= 4'd0;
            presc_r   <= 16'd0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            units_r   <= units_nxt_s;
            tens_r    <= tens_nxt_s;
            presc_r   <= presc_nxt_s;
            running_r <= (state_nxt_s == ST_RUN);
            done_r    <= done_nxt_s;
        end
    end

    // Target register: loadable whenever the count is not running, digits clamped to 9.
    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            target_r <= 8'h00;
        end else if (load && (state_r != ST_RUN)) begin
            target_r <= {clamp_digit(target[7:4]), clamp_digit(target[3:0])};
        end
    end

`ifdef BCD_LAP_EN
    logic [7:0] lap_r;

    // Lap capture of the pre-tick count in RUN/PAUSE; cleared when returning to IDLE.
    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            lap_r <= 8'h00;
        end else if ((state_nxt_s == ST_IDLE) && (state_r != ST_IDLE)) begin
            lap_r <= 8'h00;
        end else if (lap && ((state_r == ST_RUN) || (state_r == ST_PAUSE))) begin
            lap_r <= {tens_r, units_r};
        end
    end

    assign lap_value = lap_r;
`else
    assign lap_value = 8'h00;
`endif

    assign unidades = units_r;
    assign decenas  = tens_r;
    assign running  = running_r;
    assign done     = done_r;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed self-checking bench for bcd_timer_ctrl with PRESCALE=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
`timescale 1ns/1ps
module tb_bcd_timer_ctrl;

    logic       CLK = 1'b0;
    logic       Clear;
    logic       start, stop, load, lap;
    logic [7:0] target;
    logic [3:0] unidades, decenas;
    logic       running, done;
    logic [7:0] lap_value;
    wire  [7:0] cnt = {decenas, unidades};

    int checks = 0;
    int errors = 0;

    bcd_timer_ctrl #(.PRESCALE(4)) dut (
        .CLK(CLK),
        .Clear(Clear),
        .start(start),
        .stop(stop),
        .load(load),
        .target(target),
`ifdef BCD_LAP_EN
        .lap(lap),
`endif
        .unidades(unidades),
        .decenas(decenas),
        .running(running),
        .done(done),
        .lap_value(lap_value)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset;
        Clear = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; lap = 1'b0; target = 8'h00;
        #2 Clear = 1'b0;
        #1;
        checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h expected %h", cnt, 8'h00); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (lap_value !== 8'h00) begin errors++; $display("FAIL reset_lap: got %h expected 00", lap_value); end
        step(2);
        Clear = 1'b1;
        step(1);
    endtask

    // Target 12: count reaches 12 at edge 48, done pulses once, DONE freezes.
    task automatic test_count_to_target;
        load = 1'b1; target = 8'h12; step(1); load = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL t1_running_rise: got %b expected 1", running); end
        step(47);
        checks++; if (cnt !== 8'h11 || done !== 1'b0) begin errors++; $display("FAIL t1_edge47: got %h/%b expected 11/0", cnt, done); end
        step(1);
        checks++; if (cnt !== 8'h12) begin errors++; $display("FAIL t1_cnt48: got %h expected 12", cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL t1_done_pulse: got %b expected 1", done); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL t1_running_fall: got %b expected 0", running); end
        step(1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_one_cycle: got %b expected 0", done); end
        step(5);
        checks++; if (cnt !== 8'h12 || running !== 1'b0) begin errors++; $display("FAIL t1_frozen: got %h/%b expected 12/0", cnt, running); end
        stop = 1'b1; step(1); stop = 1'b0;
        checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL t1_done_stop: got %h expected 00", cnt); end
    endtask

    // Target 00 free-run for 100 ticks: 09->10, 99->00, no done.
    task automatic test_free_run;
        logic seen_done;
        seen_done = 1'b0;
        load = 1'b1; target = 8'h00; step(1); load = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            step(1);
            if (done === 1'b1) seen_done = 1'b1;
            if (i == 36) begin
                checks++; if (cnt !== 8'h09) begin errors++; $display("FAIL t2_cnt09: got %h expected 09", cnt); end
            end
            if (i == 40) begin
                checks++; if (cnt !== 8'h10) begin errors++; $display("FAIL t2_cnt10: got %h expected 10", cnt); end
            end
            if (i == 396) begin
                checks++; if (cnt !== 8'h99) begin errors++; $display("FAIL t2_cnt99: got %h expected 99", cnt); end
            end
            if (i == 400) begin
                checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL t2_wrap00: got %h expected 00", cnt); end
            end
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL t2_no_done: got %b expected 0", seen_done); end
        stop = 1'b1; step(2); stop = 1'b0;
    endtask

    // Pause at 05 with prescaler phase 2, resume ticks after 2 edges, stop in PAUSE clears.
    task automatic test_pause_resume;
        start = 1'b1; step(1); start = 1'b0;
        step(21);
        stop = 1'b1; step(1); stop = 1'b0;
        checks++; if (cnt !== 8'h05 || running !== 1'b0) begin errors++; $display("FAIL t3_paused: got %h/%b expected 05/0", cnt, running); end
        step(20);
        checks++; if (cnt !== 8'h05) begin errors++; $display("FAIL t3_hold: got %h expected 05", cnt); end
        start = 1'b1; step(1); start = 1'b0;
        checks++; if (running !== 1'b1 || cnt !== 8'h05) begin errors++; $display("FAIL t3_resume: got %h/%b expected 05/1", cnt, running); end
        step(1);
        checks++; if (cnt !== 8'h05) begin errors++; $display("FAIL t3_phase_kept: got %h expected 05", cnt); end
        step(1);
        checks++; if (cnt !== 8'h06) begin errors++; $display("FAIL t3_next_tick: got %h expected 06", cnt); end
        stop = 1'b1; step(1);
        checks++; if (cnt !== 8'h06) begin errors++; $display("FAIL t3_pause2: got %h expected 06", cnt); end
        step(1); stop = 1'b0;
        checks++; if (cnt !== 8'h00 || running !== 1'b0) begin errors++; $display("FAIL t3_to_idle: got %h/%b expected 00/0", cnt, running); end
    endtask

    // start+stop in IDLE stays IDLE; AF clamps to 99; load in RUN ignored; DONE+start restarts.
    task automatic test_start_stop_load;
        logic seen_done;
        seen_done = 1'b0;
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL t4_both_running: got %b expected 0", running); end
        step(8);
        checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL t4_both_idle: got %h expected 00", cnt); end
        load = 1'b1; target = 8'hAF; step(1); load = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        load = 1'b1; target = 8'h03; step(1); load = 1'b0;
        for (int i = 4; i <= 395; i++) begin
            step(1);
            if (done === 1'b1) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0 || cnt !== 8'h98) begin errors++; $display("FAIL t4_run_load_ignored: got %h/%b expected 98/0", cnt, seen_done); end
        step(1);
        checks++; if (cnt !== 8'h99 || done !== 1'b1) begin errors++; $display("FAIL t4_clamp99: got %h/%b expected 99/1", cnt, done); end
        start = 1'b1; step(1); start = 1'b0;
        checks++; if (cnt !== 8'h00 || running !== 1'b1) begin errors++; $display("FAIL t4_done_restart: got %h/%b expected 00/1", cnt, running); end
        stop = 1'b1; step(2); stop = 1'b0;
    endtask

    // Clear mid-RUN at 37: immediate zero, no done, target reset, restart from 00.
    task automatic test_async_clear;
        logic seen_done;
        seen_done = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(148);
        checks++; if (cnt !== 8'h37 || running !== 1'b1) begin errors++; $display("FAIL t5_at37: got %h/%b expected 37/1", cnt, running); end
        Clear = 1'b0; #2;
        checks++; if (cnt !== 8'h00 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t5_async: got %h/%b/%b expected 00/0/0", cnt, running, done); end
        #2 Clear = 1'b1;
        step(3);
        checks++; if (cnt !== 8'h00 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t5_after: got %h/%b/%b expected 00/0/0", cnt, running, done); end
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (done === 1'b1) seen_done = 1'b1;
        end
        checks++; if (cnt !== 8'h03 || seen_done !== 1'b0) begin errors++; $display("FAIL t5_restart: got %h/%b expected 03/0", cnt, seen_done); end
        stop = 1'b1; step(2); stop = 1'b0;
    endtask

    // Lap capture (or tie-off when the feature is compiled out).
    task automatic test_lap;
        start = 1'b1; step(1); start = 1'b0;
        step(92);
`ifdef BCD_LAP_EN
        lap = 1'b1; step(1); lap = 1'b0;
        checks++; if (lap_value !== 8'h23 || cnt !== 8'h23) begin errors++; $display("FAIL t6_lap23: got %h/%h expected 23/23", lap_value, cnt); end
        step(3);
        checks++; if (cnt !== 8'h24 || lap_value !== 8'h23) begin errors++; $display("FAIL t6_continue: got %h/%h expected 24/23", cnt, lap_value); end
        step(3);
        lap = 1'b1; step(1); lap = 1'b0;
        checks++; if (cnt !== 8'h25 || lap_value !== 8'h24) begin errors++; $display("FAIL t6_pretick: got %h/%h expected 25/24", cnt, lap_value); end
        stop = 1'b1; step(1);
        checks++; if (lap_value !== 8'h24) begin errors++; $display("FAIL t6_pause_keep: got %h expected 24", lap_value); end
        step(1); stop = 1'b0;
        checks++; if (lap_value !== 8'h00) begin errors++; $display("FAIL t6_idle_clear: got %h expected 00", lap_value); end
        lap = 1'b1; step(1); lap = 1'b0;
        checks++; if (lap_value !== 8'h00) begin errors++; $display("FAIL t6_idle_ignore: got %h expected 00", lap_value); end
`else
        lap = 1'b1; step(1); lap = 1'b0;
        checks++; if (lap_value !== 8'h00 || cnt !== 8'h23) begin errors++; $display("FAIL t6_tied: got %h/%h expected 00/23", lap_value, cnt); end
        stop = 1'b1; step(2); stop = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_count_to_target();
        test_free_run();
        test_pause_resume();
        test_start_stop_load();
        test_async_clear();
        test_lap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Run-control sequencer for the two-digit cascaded BCD counter (units/tens, 00–99). A start/stop/load FSM and a clock prescaler gate the count, so the pair behaves as a stopwatch with a programmable terminal value. Optional lap capture is included. It sits between the front-panel pulse inputs and the BCD display digits, replacing free-running cascade clocking with one synchronous clock domain.

## Interface
- PRESCALE, 10: CLK cycles per count tick, legal range 1–65535.
- CLK  in  1  system clock, rising edge.
- Clear  in  1  asynchronous active-low reset.
- start  in  1  start or resume request, sampled each rising edge.
- stop  in  1  pause or abort request, sampled each rising edge.
- load  in  1  target load strobe.
- target  in  8  {tens, units} BCD terminal value.
- lap  in  1  lap capture strobe. Present only with BCD_LAP_EN.
- unidades  out  4  units digit.
- decenas  out  4  tens digit.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse on reaching target.
- lap_value  out  8  captured {decenas, unidades}.

## Operation
- States:
  - IDLE: count 00, prescaler 0.
  - RUN: prescaler advances.
  - PAUSE: count and prescaler frozen.
  - DONE: count frozen at target.
- Transitions, with stop taking priority over start in the same cycle:
  - IDLE + start → RUN.
  - RUN + stop → PAUSE.
  - PAUSE + start → RUN. Resume keeps the prescaler phase.
  - PAUSE + stop → IDLE. Count and prescaler are cleared.
  - DONE + start → RUN with count cleared to 00.
  - DONE + stop → IDLE.
- Prescaler: counts 0..PRESCALE-1 in RUN. At PRESCALE-1 a tick fires and the prescaler wraps to 0.
- Tick arithmetic:
  - Units digit: +1; 9 → 0 with carry into tens.
  - Tens digit: 9 + carry → 0. 99 wraps to 00.
  - Digits never hold A–F.
- Target match: when the post-tick count equals a nonzero target, the FSM enters DONE and done pulses. Target 00 means free-run: no DONE, wrap at 99.
- Load:
  - Accepted in IDLE, PAUSE and DONE. Ignored in RUN.
  - Any target digit >9 is clamped to 9 on load.
  - Load does not change state.
- Tick and stop in the same cycle: the tick is applied, then PAUSE. If that tick hits the target, DONE wins.
- Reset: asynchronous on Clear=0. State IDLE, unidades=0, decenas=0, target register=00, prescaler=0, running=0, done=0, lap_value=00. Reset mid-RUN aborts with no done pulse.

## Timing
- All outputs are registered.
- running rises on the edge that samples start in IDLE or PAUSE. It falls on the edge that samples stop or reaches the target.
- From IDLE, the first tick lands PRESCALE edges after the start edge. The count reaches N at start edge + N·PRESCALE.
- done is high for exactly the one cycle following the edge that updates the count to the target.
- A loaded target takes effect from the next cycle's comparison.

## Configuration
- BCD_LAP_EN defined:
  - In RUN or PAUSE, a lap strobe latches the current registered {decenas, unidades} into lap_value on that edge. The value is the pre-tick value if a tick coincides.
  - lap is ignored in IDLE and DONE.
  - lap_value clears on the IDLE transition.
- BCD_LAP_EN undefined: the lap port is absent and lap_value is tied to 8'h00.

## Test plan
1. PRESCALE=4, target 8'h12, start pulse at edge 0 → running=1; count 12 at edge 48; done high for one cycle; state DONE; running=0.
2. Target 8'h00, run 100 ticks → count passes 09→10 and 99→00, reads 00 after 100 ticks, done never asserts.
3. Stop at count 05 with the prescaler mid-phase (2), hold 20 cycles, start → count unchanged while paused; next tick after 2 more edges; stop in PAUSE returns 00.
4. start and stop high together from IDLE → remains IDLE. Load 8'hAF → target register 8'h99. Load during RUN → target unchanged.
5. Clear low mid-RUN at count 37 → outputs zero immediately, no done pulse; restart counts from 00.
6. BCD_LAP_EN: lap at count 23 in RUN → lap_value 8'h23 while the count continues. Without the macro → lap_value stays 8'h00.
